// File: rtl/synapse_range_sequencer.sv
// synapse_range_sequencer
//   Sweeps every first-layer neuron and streams the synapse indices each one owns.
//   Neuron n owns the half-open range [offset[n], offset[n+1]); the last neuron
//   ends at TOTAL_SYN. Offsets come from a synchronous-read memory. The address is
//   registered, the memory samples it one edge later, and the data is captured on
//   the edge after that. Each fetched end index is reused as the next start index,
//   so every entry is read exactly once per sweep.
//
// Optional build macro: SEQ_OFFSET_CHECK_EN. When defined, an end index below the
//   start index sets the sticky err flag and ends the sweep. When undefined, such a
//   neuron is treated as empty and err is tied to 0.
//
// Ports
//   clk, rst          clock and synchronous active-high reset
//   start             one-cycle sweep request, ignored while busy
//   mem_addr          offset memory address (registered)
//   offset_data       offset memory read data
//   syn_addr          current synapse index
//   neuron_idx        neuron that owns syn_addr
//   syn_valid         syn_addr/neuron_idx/syn_last are valid
//   syn_ready         downstream accepts the beat
//   syn_last          beat is the final synapse of neuron_idx
//   busy, done, err   sweep active, end-of-sweep pulse, sticky offset error
module synapse_range_sequencer #(
  parameter int unsigned NEURON_NUM = 40,
  parameter int unsigned TOTAL_SYN  = 1020
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [5:0] mem_addr,
  input  logic [9:0] offset_data,
  output logic [9:0] syn_addr,
  output logic [5:0] neuron_idx,
  output logic       syn_valid,
  input  logic       syn_ready,
  output logic       syn_last,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [5:0] LastN    = 6'(NEURON_NUM - 1);
  localparam logic [9:0] TotalSyn = 10'(TOTAL_SYN);

  typedef enum logic [2:0] {
    StIdle, StIssue, StWait, StCapture, StStream, StFin
  } state_e;

  state_e     state;
  logic [5:0] n_cnt;
  logic       first;      // first fetch of the sweep returns start(0), not an end
  logic [9:0] cap_data;
  logic [9:0] start_idx;
  logic [9:0] end_idx;
  logic       err_flag;

  logic [9:0] end_val;
  logic [5:0] n_next;
  state_e     fetch_state;
  logic [5:0] fetch_addr;
  logic [9:0] addr_inc;
  logic       bad_order;

  always_comb begin
    end_val     = (n_cnt == LastN) ? TotalSyn : cap_data;
    n_next      = n_cnt + 6'd1;
    // The last neuron's end is TOTAL_SYN, so its fetch is skipped entirely.
    fetch_state = (n_next == LastN) ? StCapture : StIssue;
    fetch_addr  = n_next + 6'd1;
    addr_inc    = syn_addr + 10'd1;
`ifdef SEQ_OFFSET_CHECK_EN
    bad_order   = end_val < start_idx;
`else
    bad_order   = 1'b0;
`endif
  end

`ifdef SEQ_OFFSET_CHECK_EN
  assign err = err_flag;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= StIdle;
      n_cnt      <= 6'd0;
      first      <= 1'b0;
      cap_data   <= 10'd0;
      start_idx  <= 10'd0;
      end_idx    <= 10'd0;
      err_flag   <= 1'b0;
      mem_addr   <= 6'd0;
      syn_addr   <= 10'd0;
      neuron_idx <= 6'd0;
      syn_valid  <= 1'b0;
      syn_last   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (start) begin
            state    <= StIssue;
            mem_addr <= 6'd0;
            n_cnt    <= 6'd0;
            first    <= 1'b1;
            busy     <= 1'b1;
          end
        end
        // Address is stable; the memory samples it on this edge.
        StIssue: state <= StWait;
        StWait: begin
          cap_data <= offset_data;
          state    <= StCapture;
        end
        StCapture: begin
          if (first) begin
            first     <= 1'b0;
            start_idx <= cap_data;
            if (n_cnt == LastN) begin
              state <= StCapture;
            end else begin
              state    <= StIssue;
              mem_addr <= n_next;
            end
          end else if (bad_order) begin
            err_flag <= 1'b1;
            syn_valid <= 1'b0;
            done     <= 1'b1;
            state    <= StFin;
          end else if (end_val > start_idx) begin
            end_idx    <= end_val;
            syn_addr   <= start_idx;
            neuron_idx <= n_cnt;
            syn_valid  <= 1'b1;
            syn_last   <= (start_idx == end_val - 10'd1);
            state      <= StStream;
          end else begin
            // Empty neuron: its end is the next neuron's start.
            start_idx <= end_val;
            if (n_cnt == LastN) begin
              done  <= 1'b1;
              state <= StFin;
            end else begin
              n_cnt    <= n_next;
              mem_addr <= fetch_addr;
              state    <= fetch_state;
            end
          end
        end
        StStream: begin
          if (syn_ready) begin
            if (syn_last) begin
              syn_valid <= 1'b0;
              syn_last  <= 1'b0;
              start_idx <= end_idx;
              if (n_cnt == LastN) begin
                done  <= 1'b1;
                state <= StFin;
              end else begin
                n_cnt    <= n_next;
                mem_addr <= fetch_addr;
                state    <= fetch_state;
              end
            end else begin
              syn_addr <= addr_inc;
              syn_last <= (addr_inc == end_idx - 10'd1);
            end
          end
        end
        StFin: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_synapse_range_sequencer.sv
module tb_synapse_range_sequencer;

  localparam int NN  = 40;
  localparam int TOT = 1020;

  logic       clk;
  logic       rst;
  logic       start;
  logic [5:0] mem_addr;
  logic [9:0] offset_data;
  logic [9:0] syn_addr;
  logic [5:0] neuron_idx;
  logic       syn_valid;
  logic       syn_ready;
  logic       syn_last;
  logic       busy;
  logic       done;
  logic       err;

  synapse_range_sequencer #(
    .NEURON_NUM(NN),
    .TOTAL_SYN (TOT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mem_addr   (mem_addr),
    .offset_data(offset_data),
    .syn_addr   (syn_addr),
    .neuron_idx (neuron_idx),
    .syn_valid  (syn_valid),
    .syn_ready  (syn_ready),
    .syn_last   (syn_last),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read offset memory.
  logic [9:0] mem [64];
  always @(posedge clk) offset_data <= mem[mem_addr];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: expected beats as {neuron, addr, last}.
  int          off [64];
  logic [31:0] exp_q[$];
  logic        exp_err;
  int          exp_beats;

  task automatic build_model();
    int s, e;
    exp_q.delete();
    exp_err   = 1'b0;
    exp_beats = 0;
    for (int n = 0; n < NN; n++) begin
      s = off[n];
      e = (n == NN - 1) ? TOT : off[n + 1];
`ifdef SEQ_OFFSET_CHECK_EN
      if (e < s) begin
        exp_err = 1'b1;
        break;
      end
`endif
      for (int a = s; a < e; a++) begin
        exp_q.push_back(32'((n << 11) | (a << 1) | ((a == e - 1) ? 1 : 0)));
        exp_beats++;
      end
    end
  endtask

  // Monitor: drives ready for the coming edge, then samples outputs mid-cycle.
  int          ready_mode = 0;
  logic        track = 1'b0;
  logic        hold_pend = 1'b0;
  logic [31:0] held;
  logic        done_prev = 1'b0;
  int          done_cnt = 0;
  int          beats = 0;

  always @(negedge clk) begin
    case (ready_mode)
      0:       syn_ready = 1'b1;
      1:       syn_ready = ~syn_ready;
      default: syn_ready = 1'($urandom_range(0, 1));
    endcase
    if (track && !rst) begin
      if (hold_pend)
        check("hold_stable", {14'd0, syn_valid, neuron_idx, syn_addr, syn_last}, held);
      if (syn_valid && syn_ready) begin
        if (exp_q.size() == 0) check("extra_beat", 1, 0);
        else check("beat", {15'd0, neuron_idx, syn_addr, syn_last}, exp_q.pop_front());
        beats++;
      end
      hold_pend = syn_valid && !syn_ready;
      held      = {14'd0, syn_valid, neuron_idx, syn_addr, syn_last};
      if (done_prev) check("busy_after_done", {31'd0, busy}, 0);
      done_prev = done;
      if (done) begin
        check("busy_in_fin", {31'd0, busy}, 1);
        done_cnt++;
      end
    end else begin
      hold_pend = 1'b0;
      done_prev = 1'b0;
    end
  end

  task automatic check_outputs_zero(input string tag);
    check(tag, {14'd0, mem_addr, syn_addr, neuron_idx, syn_valid, syn_last, busy, done, err}, 0);
  endtask

  task automatic do_reset();
    track = 1'b0;
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs_zero("reset_outputs");
    rst = 1'b0;
  endtask

  task automatic run_sweep(input int mode, input bit with_reset);
    int cyc;
    for (int i = 0; i < 64; i++) mem[i] = (i < NN) ? 10'(off[i]) : 10'd0;
    build_model();
    if (with_reset) do_reset();
    @(negedge clk);
    ready_mode = mode;
    done_cnt   = 0;
    beats      = 0;
    track      = 1'b1;
    start      = 1'b1;  // held high through the sweep: must be ignored while busy
    cyc = 0;
    while (done_cnt == 0 && cyc < 8000) begin
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    start = 1'b0;
    check("done_seen", {31'd0, done_cnt > 0}, 1);
    repeat (40) @(negedge clk);
    check("done_count", done_cnt, 1);
    check("beat_count", beats, exp_beats);
    check("beats_left", exp_q.size(), 0);
    check("err", {31'd0, err}, {31'd0, exp_err});
    check("idle_after", {30'd0, busy, syn_valid}, 0);
    track = 1'b0;
  endtask

  task automatic set_linear(input int step);
    for (int i = 0; i < 64; i++) off[i] = (i < NN) ? step * i : 0;
  endtask

  initial begin
    int cyc;
    rst = 1'b0;
    start = 1'b0;
    syn_ready = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 10'd0;

    set_linear(25);
    run_sweep(0, 1'b1);
    run_sweep(1, 1'b1);

    set_linear(25);
    off[3] = 75;
    off[4] = 75;
    run_sweep(2, 1'b1);

    // Mid-sweep reset at the 100th accepted beat.
    set_linear(25);
    for (int i = 0; i < 64; i++) mem[i] = (i < NN) ? 10'(off[i]) : 10'd0;
    build_model();
    do_reset();
    @(negedge clk);
    ready_mode = 0;
    done_cnt   = 0;
    beats      = 0;
    track      = 1'b1;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (beats < 100 && cyc < 3000) begin
      @(posedge clk);
      cyc++;
    end
    check("reached_100", {31'd0, beats >= 100}, 1);
    @(negedge clk);
    track = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    check("valid_after_rst", {31'd0, syn_valid}, 0);
    check_outputs_zero("mid_rst_outputs");
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("no_done_after_rst", {31'd0, done}, 0);
    check("mid_done_count", done_cnt, 0);
    run_sweep(0, 1'b0);

    // Descending pair at entries 10/11.
    set_linear(15);
    off[10] = 200;
    off[11] = 150;
    off[12] = 180;
    run_sweep(0, 1'b1);

    for (int t = 0; t < 3; t++) begin
      off[0] = $urandom_range(0, 30);
      for (int i = 1; i < NN; i++) begin
        off[i] = off[i - 1] + (($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 40));
        if (off[i] > TOT) off[i] = TOT;
      end
      run_sweep(2, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/synapse_range_sequencer.md
SYNAPSE_RANGE_SEQUENCER -- requirements
Module: synapse_range_sequencer

Interface
REQ-001 The block SHALL have parameter NEURON_NUM, default 40, meaning the number of first-layer neurons and the number of offset memory entries.
REQ-002 The block SHALL have parameter TOTAL_SYN, default 1020, meaning the exclusive end index of the last neuron's synapse range (10-bit).
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, meaning the synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1, meaning a one-cycle request to sweep all neurons.
REQ-006 The block SHALL have port mem_addr, output, 6, meaning the registered address to the offset memory.
REQ-007 The block SHALL have port offset_data, input, 10, meaning the offset memory read data.
REQ-008 The block SHALL have port syn_addr, output, 10, meaning the current synapse index.
REQ-009 The block SHALL have port neuron_idx, output, 6, meaning the neuron that owns syn_addr.
REQ-010 The block SHALL have port syn_valid, output, 1, meaning syn_addr and neuron_idx are valid.
REQ-011 The block SHALL have port syn_ready, input, 1, meaning the downstream accumulator accepts the beat.
REQ-012 The block SHALL have port syn_last, output, 1, meaning the beat is the final synapse of neuron_idx.
REQ-013 The block SHALL have ports busy (output, 1, sweep in progress), done (output, 1, one-cycle end-of-sweep pulse) and err (output, 1, sticky offset error).

Function
REQ-014 Offset entry n SHALL hold the start index of neuron n. The end index SHALL be entry n+1, or TOTAL_SYN for n = NEURON_NUM-1. The range is the half-open interval [start, end).
REQ-015 Memory timing SHALL be: mem_addr is updated at edge E0, the memory samples it at E1, and the block captures offset_data at E2.
REQ-016 The FSM SHALL have the states IDLE, ISSUE, WAIT, CAPTURE, STREAM and FIN.
REQ-017 IDLE SHALL go to ISSUE on start, with mem_addr=0 and neuron counter n=0. The first pass captures start(0) and then loops back to ISSUE with mem_addr=n+1.
REQ-018 For n = NEURON_NUM-1 the block SHALL skip the memory fetch and use TOTAL_SYN as end directly.
REQ-019 On capture of end(n), the FSM SHALL go to STREAM if end>start and directly to the next fetch otherwise (empty neuron, no beats).
REQ-020 In STREAM, syn_valid SHALL be 1 and syn_addr SHALL run from start to end-1, advancing only on a cycle where syn_valid and syn_ready are both high. syn_last SHALL be 1 when syn_addr = end-1.
REQ-021 syn_addr, neuron_idx and syn_last SHALL hold stable while syn_valid=1 and syn_ready=0.
REQ-022 After an accepted last beat, end(n) SHALL become start(n+1) without refetching. The FSM SHALL go to FIN after neuron NEURON_NUM-1, otherwise to ISSUE.
REQ-023 FIN SHALL pulse done for one cycle, then return to IDLE. busy SHALL be 1 in every state except IDLE.
REQ-024 start SHALL be ignored while busy=1, including the FIN cycle.
REQ-025 Index arithmetic SHALL be 10-bit unsigned with no wrap. The maximum syn_addr is TOTAL_SYN-1.

Reset
REQ-026 On rst, the FSM SHALL go to IDLE and all outputs SHALL go to 0: mem_addr, syn_addr, neuron_idx, syn_valid, syn_last, busy, done and err.
REQ-027 An rst mid-sweep SHALL abandon the sweep, drive syn_valid=0 on the next cycle, and produce no done pulse.

Configuration
REQ-028 With macro SEQ_OFFSET_CHECK_EN defined, a captured end < start SHALL set err (sticky until rst), drop syn_valid, and go to FIN with a done pulse.
REQ-029 Without SEQ_OFFSET_CHECK_EN, end < start SHALL be treated as an empty neuron, and err SHALL be tied to 0.

Verification
REQ-030 Offsets 0,25,50,...,975 with TOTAL_SYN=1020 and syn_ready=1 -> 1020 beats (syn_addr 0..1019), 40 syn_last pulses, one done pulse, busy falling 1 cycle after done.
REQ-031 Same offsets with syn_ready toggling 1,0 each cycle -> identical beat sequence, with outputs held stable during each ready=0 cycle.
REQ-032 Entries 3 and 4 both equal to 75 -> neuron 3 emits no beats and neuron 4 starts at syn_addr=75.
REQ-033 rst asserted at the 100th accepted beat -> syn_valid=0 on the next cycle, no done pulse, and a new start sweeps again from syn_addr=0.
REQ-034 Entry 10 = 200 and entry 11 = 150, with SEQ_OFFSET_CHECK_EN -> err=1 and done pulse after neuron 10; without the macro -> neuron 10 emits no beats and the sweep continues.
REQ-035 start asserted while busy=1 -> no restart and exactly one done pulse for the sweep.
